// File: rtl/display_pkg.sv
// Shared constants for the multiplexed seven-segment display: segment table
// (g..a, active-low) and output polarity values.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic AN_ON   = 1'b0;
  localparam logic AN_OFF  = 1'b1;
  localparam logic DP_ON   = 1'b0;
  localparam logic DP_OFF  = 1'b1;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_decoder.sv
// Hex nibble to active-low seven-segment pattern (g..a), purely combinational.
module seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/multi_digit_display.sv
// Time-multiplexed hex display driver with double-buffered digit data,
// leading-zero suppression and per-slot PWM brightness.
module multi_digit_display
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_W    = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              CA,
  output logic                    DP,
  output logic                    frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam logic [31:0] STEP = 32'(REFRESH_DIV >> BRIGHT_W);

  logic [PW-1:0] prescaler;
  logic [SW-1:0] slot;
  logic          presc_wrap;
  logic          frame_edge;

  logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic [NUM_DIGITS-1:0]   pend_blank, act_blank;

  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  lz_chain;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_blank, cur_lz;
  logic [6:0]            dec_seg;
  logic [31:0]           on_lim;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            ca_next;
  logic                  dp_next;

  assign presc_wrap = (prescaler == PW'(REFRESH_DIV - 1));
  assign frame_edge = presc_wrap && (slot == SW'(NUM_DIGITS - 1));
  assign frame_done = frame_edge & ~Reset;

  // Suppression runs from the most significant digit down and stops at the
  // first nonzero nibble or set decimal point; digit 0 is never suppressed.
  always_comb begin
    lz_chain = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_chain   = lz_chain & lz_suppress & (act_digits[4*i +: 4] == 4'h0) & ~act_dp[i];
      lz_mask[i] = lz_chain;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot == SW'(i)) begin
        cur_nib   = act_digits[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_blank = act_blank[i];
        cur_lz    = lz_mask[i];
      end
    end
  end

  seg_decoder u_seg_decoder (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  assign on_lim = (32'(brightness) + 32'd1) * STEP;

  always_comb begin
    an_next = {NUM_DIGITS{AN_OFF}};
    if (32'(prescaler) < on_lim) an_next[slot] = AN_ON;
    if (cur_blank || cur_lz) begin
      ca_next = SEG_BLANK;
      dp_next = DP_OFF;
    end else begin
      ca_next = dec_seg;
      dp_next = cur_dp ? DP_ON : DP_OFF;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      prescaler   <= '0;
      slot        <= '0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      act_digits  <= '0;
      act_dp      <= '0;
      act_blank   <= '0;
      AN          <= {NUM_DIGITS{AN_OFF}};
      CA          <= SEG_BLANK;
      DP          <= DP_OFF;
    end else begin
      prescaler <= presc_wrap ? '0 : prescaler + PW'(1);
      if (presc_wrap) slot <= (slot == SW'(NUM_DIGITS - 1)) ? '0 : slot + SW'(1);
      if (load) begin
        pend_digits <= digits;
        pend_dp     <= dp_in;
        pend_blank  <= blank_in;
      end
      // A load on the boundary cycle lands in pending only; active takes the old pending.
      if (frame_edge) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
        act_blank  <= pend_blank;
      end
      AN <= an_next;
      CA <= ca_next;
      DP <= dp_next;
    end
  end

endmodule

// File: tb/tb_multi_digit_display.sv
// Directed bench for multi_digit_display with 4 digits, 16-cycle slots, 2-bit brightness.
module tb_multi_digit_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp_in, blank_in;
  logic        load, lz_suppress;
  logic [1:0]  brightness;
  logic [3:0]  an;
  logic [6:0]  ca;
  logic        dp, frame_done;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  multi_digit_display #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (16),
    .BRIGHT_W    (2)
  ) dut (
    .Clock       (clk),
    .Reset       (rst),
    .digits      (digits),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .load        (load),
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .AN          (an),
    .CA          (ca),
    .DP          (dp),
    .frame_done  (frame_done)
  );

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
    logic [27:0] ca;   // {slot3, slot2, slot1, slot0}
    logic [3:0]  dpo;  // expected DP per slot
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (frame_done) seen = 1'b1;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL wait_frame: got no frame_done expected pulse within 200 cycles");
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl);
    if (frame_done) tick();
    digits   = d;
    dp_in    = dpv;
    blank_in = bl;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [6:0] exp_ca;
    logic [3:0] exp_an;

    vecs[0] = '{16'h12AF, 4'h0, 4'h0, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111};
    vecs[1] = '{16'h0050, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
    vecs[2] = '{16'h0050, 4'h4, 4'h0, 1'b1, {7'h7F, 7'h40, 7'h12, 7'h40}, 4'b1011};
    vecs[3] = '{16'h0000, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    vecs[4] = '{16'h8421, 4'hF, 4'h5, 1'b0, {7'h00, 7'h7F, 7'h24, 7'h7F}, 4'b0101};
    vecs[5] = '{16'h0C0D, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h46, 7'h40, 7'h21}, 4'b1111};
    vecs[6] = '{16'h3E6B, 4'h0, 4'h0, 1'b0, {7'h30, 7'h06, 7'h02, 7'h03}, 4'b1111};
    vecs[7] = '{16'h7940, 4'h0, 4'h0, 1'b0, {7'h78, 7'h10, 7'h19, 7'h40}, 4'b1111};

    rst = 1'b1; load = 1'b0; digits = '0; dp_in = '0; blank_in = '0;
    lz_suppress = 1'b0; brightness = 2'b11;
    step(3);
    check("reset_an", 32'(an), 32'hF);
    check("reset_ca", 32'(ca), 32'h7F);
    check("reset_dp", 32'(dp), 32'h1);
    check("reset_fd", 32'(frame_done), 32'h0);

    // Release: n counts edges after release; outputs reflect slot (n-1)/16.
    rst = 1'b0;
    tick();
    for (int s = 0; s < 4; s++) begin
      if (s > 0) step(16);
      exp_an = ~(4'b0001 << s);
      check($sformatf("scan_an_slot%0d", s), 32'(an), 32'(exp_an));
      check($sformatf("scan_ca_slot%0d", s), 32'(ca), 32'h40);
    end
    step(13);
    check("fd_before_boundary", 32'(frame_done), 32'h0);
    tick();
    check("fd_at_boundary", 32'(frame_done), 32'h1);
    tick();
    check("fd_after_boundary", 32'(frame_done), 32'h0);
    cnt = 1;
    for (int i = 0; i < 100 && !frame_done; i++) begin
      tick();
      if (!frame_done) cnt++;
    end
    check("frame_period", 32'(cnt + 1), 32'd64);

    for (int b = 0; b < 4; b++) begin
      brightness = 2'(b);
      tick();
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
        tick();
        if (an != 4'hF) cnt++;
      end
      check($sformatf("duty_bright%0d", b), 32'(cnt), 32'((b + 1) * 16));
    end
    brightness = 2'b11;

    wait_frame();
    step(5);
    do_load(16'h12AF, 4'h0, 4'h0);
    step(3);
    check("hold_until_frame", 32'(ca), 32'h40);

    for (int v = 0; v < 8; v++) begin
      lz_suppress = vecs[v].lz;
      do_load(vecs[v].digits, vecs[v].dp, vecs[v].blank);
      wait_frame();
      step(2);
      for (int s = 0; s < 4; s++) begin
        if (s > 0) step(16);
        exp_an = ~(4'b0001 << s);
        exp_ca = vecs[v].ca[7*s +: 7];
        check($sformatf("v%0d_an_s%0d", v, s), 32'(an), 32'(exp_an));
        check($sformatf("v%0d_ca_s%0d", v, s), 32'(ca), 32'(exp_ca));
        check($sformatf("v%0d_dp_s%0d", v, s), 32'(dp), 32'(vecs[v].dpo[s]));
      end
    end
    lz_suppress = 1'b0;

    do_load(16'h2222, 4'h0, 4'h0);
    do_load(16'h3333, 4'h0, 4'h0);
    wait_frame();
    step(2);
    check("last_load_wins", 32'(ca), 32'h30);

    do_load(16'h1111, 4'h0, 4'h0);
    wait_frame();
    digits = 16'h5A5A;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    tick();
    check("boundary_load_old_pending", 32'(ca), 32'h79);
    wait_frame();
    step(2);
    check("boundary_load_next_frame_s0", 32'(ca), 32'h08);
    step(16);
    check("boundary_load_next_frame_s1", 32'(ca), 32'h12);

    step(21);
    do_load(16'h7777, 4'h0, 4'h0);
    rst = 1'b1;
    tick();
    check("midreset_an", 32'(an), 32'hF);
    check("midreset_ca", 32'(ca), 32'h7F);
    check("midreset_dp", 32'(dp), 32'h1);
    check("midreset_fd", 32'(frame_done), 32'h0);
    rst = 1'b0;
    tick();
    check("post_reset_an", 32'(an), 32'hE);
    check("post_reset_ca", 32'(ca), 32'h40);
    wait_frame();
    step(2);
    check("pending_discarded", 32'(ca), 32'h40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
